// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared sizes, state encoding and request record for mem_access_ctrl
package mem_access_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_WRITE = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   localparam int LAT_W = 4;

   typedef struct packed {
      logic        write;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   // Half must sit on an even byte, word on a multiple of four.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      return ((size == SIZE_HALF) && lo[0]) || ((size == SIZE_WORD) && (lo != 2'b00));
   endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - request/response channel and word-wide memory bus interfaces
interface mem_req_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

interface mem_bus_if;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Addr;
   logic [31:0] Wdata;
   logic [31:0] Rdata;

   modport master (
      output MemRead, MemWrite, Addr, Wdata,
      input  Rdata
   );

   modport slave (
      input  MemRead, MemWrite, Addr, Wdata,
      output Rdata
   );
endinterface

// File: rtl/mem_access_ctrl_lane_unit.sv
// rtl/mem_access_ctrl_lane_unit.sv - little-endian byte/half lane extraction and store merge
module mem_lane_unit
   import mem_access_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  addr_i,
   input  logic [1:0]  size_i,
   input  logic        unsigned_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{addr_i, 3'b000} +: 8];
      half_sel = word_i[{addr_i[1], 4'b0000} +: 16];
      load_o   = word_i;
      merge_o  = wdata_i;
      case (size_i)
         SIZE_BYTE: begin
            load_o  = unsigned_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            merge_o = word_i;
            merge_o[{addr_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SIZE_HALF: begin
            load_o  = unsigned_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            merge_o = word_i;
            merge_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: begin
            load_o  = word_i;
            merge_o = wdata_i;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage load/store initiator with read-modify-write sub-word stores
// Optional: MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into error responses.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int DEPTH   = 50,
   parameter int MEM_LAT = 1
)(
   input logic        clk,
   input logic        rst,
   mem_req_if.slave   req,
   mem_bus_if.master  bus
);

   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LAT - 1);

   logic [1:0]       state_q, state_d;
   logic [LAT_W-1:0] lat_q, lat_d;
   req_t             req_q, req_d;
   logic             err_q, err_d;
   logic [31:0]      word_q, word_d;
   logic             mem_read_q, mem_read_d;
   logic             mem_write_q, mem_write_d;

   logic             req_err;
   logic             addr_oob;
   logic             size_bad;
   logic             misalign;
   logic [31:0]      load_data;
   logic [31:0]      merge_data;

   mem_lane_unit u_lane (
      .word_i     (word_q),
      .addr_i     (req_q.addr[1:0]),
      .size_i     (req_q.size),
      .unsigned_i (req_q.uns),
      .wdata_i    (req_q.wdata),
      .load_o     (load_data),
      .merge_o    (merge_data)
   );

   always_comb begin
      addr_oob = (req.req_addr[31:2] >= 30'(DEPTH));
      size_bad = (req.req_size == 2'b11);
`ifdef MEM_MISALIGN_TRAP_EN
      misalign = misaligned(req.req_size, req.req_addr[1:0]);
`else
      misalign = 1'b0;
`endif
      req_err = addr_oob || size_bad || misalign;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         lat_q       <= '0;
         req_q       <= '0;
         err_q       <= 1'b0;
         word_q      <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         req_q       <= req_d;
         err_q       <= err_d;
         word_q      <= word_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
      end
   end

   always_comb begin
      state_d = state_q;
      lat_d   = lat_q;
      req_d   = req_q;
      err_d   = err_q;
      word_d  = word_q;
      case (state_q)
         ST_IDLE: begin
            if (req.req_valid) begin
               req_d = '{write: req.req_write, size: req.req_size, uns: req.req_unsigned,
                         addr: req.req_addr, wdata: req.req_wdata};
               err_d = req_err;
               lat_d = '0;
               if (req_err)
                  state_d = ST_RESP;
               else if (!req.req_write || (req.req_size != SIZE_WORD))
                  state_d = ST_READ;
               else
                  state_d = ST_WRITE;
            end
         end
         ST_READ: begin
            // The word lands in the merge buffer for both loads and sub-word stores.
            if (lat_q == LAT_LAST) begin
               word_d  = bus.Rdata;
               lat_d   = '0;
               state_d = req_q.write ? ST_WRITE : ST_RESP;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         ST_WRITE: state_d = ST_RESP;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_read_d     = (state_d == ST_READ);
      mem_write_d    = (state_d == ST_WRITE);
      req.req_ready  = (state_q == ST_IDLE);
      req.resp_valid = (state_q == ST_RESP);
      req.resp_err   = (state_q == ST_RESP) && err_q;
      req.resp_rdata = ((state_q == ST_RESP) && !err_q && !req_q.write) ? load_data : 32'h0;
      bus.MemRead    = mem_read_q;
      bus.MemWrite   = mem_write_q;
      bus.Addr       = (mem_read_q || mem_write_q) ? {2'b00, req_q.addr[31:2]} : 32'h0;
      // For word stores the lane unit passes the store data straight through.
      bus.Wdata      = mem_write_q ? merge_data : 32'h0;
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
   import mem_access_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic load_mem;
   always #5 clk = ~clk;

   mem_req_if rq1 ();
   mem_bus_if mb1 ();
   mem_req_if rq3 ();
   mem_bus_if mb3 ();

   mem_access_ctrl #(.DEPTH(50), .MEM_LAT(1)) dut (
      .clk (clk), .rst (rst), .req (rq1.slave), .bus (mb1.master)
   );

   mem_access_ctrl #(.DEPTH(50), .MEM_LAT(3)) dut3 (
      .clk (clk), .rst (rst), .req (rq3.slave), .bus (mb3.master)
   );

   logic [31:0] mem [0:63];
   assign mb1.Rdata = mem[mb1.Addr[5:0]];
   assign mb3.Rdata = mem[mb3.Addr[5:0]];

   always @(posedge clk) begin
      if (load_mem) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[1] <= 32'h11223344;
         mem[2] <= 32'h8899AABB;
      end else if (mb1.MemWrite) begin
         mem[mb1.Addr[5:0]] <= mb1.Wdata;
      end
   end

   int n_vec  = 0;
   int n_fail = 0;

   int          rdc, wrc, lat, rdy_hi, bad;
   logic [31:0] raddr, waddr, wdat, rdata;
   logic        err, rdy0;

   task automatic run_req(input bit sel3, input logic wr, input logic [1:0] sz, input logic un,
                          input logic [31:0] ad, input logic [31:0] wd);
      logic rd_s, we_s, rv_s, rdy_s;
      logic [31:0] a_s, w_s;
      @(negedge clk);
      if (sel3) begin
         rq3.req_valid = 1'b1; rq3.req_write = wr; rq3.req_size = sz;
         rq3.req_unsigned = un; rq3.req_addr = ad; rq3.req_wdata = wd;
         rdy0 = rq3.req_ready;
      end else begin
         rq1.req_valid = 1'b1; rq1.req_write = wr; rq1.req_size = sz;
         rq1.req_unsigned = un; rq1.req_addr = ad; rq1.req_wdata = wd;
         rdy0 = rq1.req_ready;
      end
      @(posedge clk); #1;
      rq1.req_valid = 1'b0;
      rq3.req_valid = 1'b0;
      rdc = 0; wrc = 0; lat = -1; rdy_hi = 0; bad = 0;
      raddr = 32'hX; waddr = 32'hX; wdat = 32'hX; rdata = 32'hX; err = 1'bX;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         rd_s  = sel3 ? mb3.MemRead    : mb1.MemRead;
         we_s  = sel3 ? mb3.MemWrite   : mb1.MemWrite;
         a_s   = sel3 ? mb3.Addr       : mb1.Addr;
         w_s   = sel3 ? mb3.Wdata      : mb1.Wdata;
         rv_s  = sel3 ? rq3.resp_valid : rq1.resp_valid;
         rdy_s = sel3 ? rq3.req_ready  : rq1.req_ready;
         if (rd_s) begin rdc++; raddr = a_s; end
         if (we_s) begin wrc++; waddr = a_s; wdat = w_s; end
         if (rd_s && we_s) bad++;
         if (!rd_s && !we_s && (a_s != 32'h0 || w_s != 32'h0)) bad++;
         if (rdy_s) rdy_hi++;
         if (rv_s) begin
            lat   = c;
            rdata = sel3 ? rq3.resp_rdata : rq1.resp_rdata;
            err   = sel3 ? rq3.resp_err   : rq1.resp_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; load_mem = 1'b1;
      rq1.req_valid = 0; rq1.req_write = 0; rq1.req_size = 0; rq1.req_unsigned = 0; rq1.req_addr = 0; rq1.req_wdata = 0;
      rq3.req_valid = 0; rq3.req_write = 0; rq3.req_size = 0; rq3.req_unsigned = 0; rq3.req_addr = 0; rq3.req_wdata = 0;
      repeat (3) @(negedge clk);
      n_vec++; if (rq1.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b want 1", rq1.req_ready); end
      n_vec++; if (rq1.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid got %b want 0", rq1.resp_valid); end
      n_vec++; if (rq1.resp_err !== 1'b0) begin n_fail++; $display("FAIL rst_resp_err got %b want 0", rq1.resp_err); end
      n_vec++; if (rq1.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_resp_rdata got %h want 0", rq1.resp_rdata); end
      n_vec++; if ({mb1.MemRead, mb1.MemWrite} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got %b want 00", {mb1.MemRead, mb1.MemWrite}); end
      n_vec++; if ({mb1.Addr, mb1.Wdata} !== 64'h0) begin n_fail++; $display("FAIL rst_bus got %h want 0", {mb1.Addr, mb1.Wdata}); end
      rst = 1'b0;
      @(negedge clk);
      load_mem = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_loads();
      run_req(0, 0, SIZE_WORD, 0, 32'h08, 32'h0);
      n_vec++; if (rdc !== 1) begin n_fail++; $display("FAIL lw_read_cycles got %0d want 1", rdc); end
      n_vec++; if (raddr !== 32'd2) begin n_fail++; $display("FAIL lw_addr got %h want 2", raddr); end
      n_vec++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency got %0d want 2", lat); end
      n_vec++; if (rdata !== 32'h8899AABB) begin n_fail++; $display("FAIL lw_rdata got %h want 8899aabb", rdata); end
      n_vec++; if (err !== 1'b0) begin n_fail++; $display("FAIL lw_err got %b want 0", err); end
      n_vec++; if (wrc !== 0 || bad !== 0 || rdy_hi !== 0) begin n_fail++; $display("FAIL lw_bus got wr=%0d bad=%0d rdy=%0d want 0 0 0", wrc, bad, rdy_hi); end
      run_req(0, 0, SIZE_BYTE, 0, 32'h0B, 32'h0);
      n_vec++; if (rdata !== 32'hFFFFFF88) begin n_fail++; $display("FAIL lb_rdata got %h want ffffff88", rdata); end
      run_req(0, 0, SIZE_BYTE, 1, 32'h0B, 32'h0);
      n_vec++; if (rdata !== 32'h00000088) begin n_fail++; $display("FAIL lbu_rdata got %h want 00000088", rdata); end
      run_req(0, 0, SIZE_HALF, 1, 32'h0A, 32'h0);
      n_vec++; if (rdata !== 32'h00008899) begin n_fail++; $display("FAIL lhu_rdata got %h want 00008899", rdata); end
      run_req(0, 0, SIZE_HALF, 0, 32'h08, 32'h0);
      n_vec++; if (rdata !== 32'hFFFFAABB) begin n_fail++; $display("FAIL lh_rdata got %h want ffffaabb", rdata); end
      run_req(0, 0, SIZE_BYTE, 1, 32'h09, 32'h0);
      n_vec++; if (rdata !== 32'h000000AA) begin n_fail++; $display("FAIL lbu1_rdata got %h want 000000aa", rdata); end
   endtask

   task automatic test_lat3_back_to_back();
      run_req(1, 0, SIZE_WORD, 0, 32'h08, 32'h0);
      n_vec++; if (rdc !== 3) begin n_fail++; $display("FAIL lat3_read_cycles got %0d want 3", rdc); end
      n_vec++; if (lat !== 4) begin n_fail++; $display("FAIL lat3_latency got %0d want 4", lat); end
      n_vec++; if (rdata !== 32'h8899AABB) begin n_fail++; $display("FAIL lat3_rdata got %h want 8899aabb", rdata); end
      n_vec++; if (rdy_hi !== 0) begin n_fail++; $display("FAIL lat3_ready_low got %0d high cycles want 0", rdy_hi); end
      run_req(1, 0, SIZE_WORD, 0, 32'h04, 32'h0);
      n_vec++; if (rdy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", rdy0); end
      n_vec++; if (lat !== 4 || rdata !== 32'h11223344) begin n_fail++; $display("FAIL b2b_resp got lat=%0d rdata=%h want 4 11223344", lat, rdata); end
   endtask

   task automatic test_subword_store();
      run_req(0, 1, SIZE_BYTE, 0, 32'h05, 32'h000000EE);
      n_vec++; if (rdc !== 1 || wrc !== 1) begin n_fail++; $display("FAIL sb_cycles got rd=%0d wr=%0d want 1 1", rdc, wrc); end
      n_vec++; if (waddr !== 32'd1) begin n_fail++; $display("FAIL sb_addr got %h want 1", waddr); end
      n_vec++; if (wdat !== 32'h1122EE44) begin n_fail++; $display("FAIL sb_wdata got %h want 1122ee44", wdat); end
      n_vec++; if (err !== 1'b0 || rdata !== 32'h0 || lat !== 3) begin n_fail++; $display("FAIL sb_resp got err=%b rdata=%h lat=%0d want 0 0 3", err, rdata, lat); end
      n_vec++; if (bad !== 0) begin n_fail++; $display("FAIL sb_bus_invariant got %0d want 0", bad); end
      n_vec++; if (mem[1] !== 32'h1122EE44) begin n_fail++; $display("FAIL sb_mem got %h want 1122ee44", mem[1]); end
   endtask

   task automatic test_boundary();
      run_req(0, 1, SIZE_WORD, 0, 32'hC8, 32'h12345678);
      n_vec++; if (rdc !== 0 || wrc !== 0) begin n_fail++; $display("FAIL oob_bus got rd=%0d wr=%0d want 0 0", rdc, wrc); end
      n_vec++; if (err !== 1'b1 || rdata !== 32'h0 || lat !== 1) begin n_fail++; $display("FAIL oob_resp got err=%b rdata=%h lat=%0d want 1 0 1", err, rdata, lat); end
      run_req(0, 1, SIZE_WORD, 0, 32'hC4, 32'hCAFEF00D);
      n_vec++; if (rdc !== 0 || wrc !== 1 || waddr !== 32'd49 || wdat !== 32'hCAFEF00D) begin n_fail++; $display("FAIL top_sw got rd=%0d wr=%0d addr=%h data=%h want 0 1 31 cafef00d", rdc, wrc, waddr, wdat); end
      n_vec++; if (err !== 1'b0 || lat !== 2) begin n_fail++; $display("FAIL top_sw_resp got err=%b lat=%0d want 0 2", err, lat); end
      n_vec++; if (mem[49] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL top_sw_mem got %h want cafef00d", mem[49]); end
      run_req(0, 0, 2'b11, 0, 32'h08, 32'h0);
      n_vec++; if (rdc !== 0 || err !== 1'b1 || rdata !== 32'h0 || lat !== 1) begin n_fail++; $display("FAIL size11 got rd=%0d err=%b rdata=%h lat=%0d want 0 1 0 1", rdc, err, rdata, lat); end
   endtask

   task automatic test_misalign();
      run_req(0, 0, SIZE_HALF, 0, 32'h0B, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
      n_vec++; if (rdc !== 0 || wrc !== 0 || err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL misalign_trap got rd=%0d wr=%0d err=%b rdata=%h want 0 0 1 0", rdc, wrc, err, rdata); end
`else
      n_vec++; if (rdc !== 1 || err !== 1'b0 || rdata !== 32'hFFFF8899) begin n_fail++; $display("FAIL misalign_ignore got rd=%0d err=%b rdata=%h want 1 0 ffff8899", rdc, err, rdata); end
`endif
   endtask

   task automatic test_reset_mid_write();
      int bad_cnt;
      @(negedge clk);
      rq1.req_valid = 1'b1; rq1.req_write = 1'b1; rq1.req_size = SIZE_HALF;
      rq1.req_unsigned = 1'b0; rq1.req_addr = 32'h06; rq1.req_wdata = 32'h0000ABCD;
      @(posedge clk); #1;
      rq1.req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_vec++; if (mb1.MemWrite !== 1'b1 || mb1.Wdata !== 32'hABCDEE44) begin n_fail++; $display("FAIL sh_write got we=%b data=%h want 1 abcdee44", mb1.MemWrite, mb1.Wdata); end
      #1 rst = 1'b1;
      #1;
      n_vec++; if (mb1.MemWrite !== 1'b0 || mb1.Addr !== 32'h0) begin n_fail++; $display("FAIL async_drop got we=%b addr=%h want 0 0", mb1.MemWrite, mb1.Addr); end
      @(negedge clk);
      rst = 1'b0;
      bad_cnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (rq1.req_ready !== 1'b1 || rq1.resp_valid !== 1'b0) bad_cnt++;
      end
      n_vec++; if (bad_cnt !== 0) begin n_fail++; $display("FAIL post_rst_idle got %0d bad cycles want 0", bad_cnt); end
      n_vec++; if (mem[1] !== 32'h1122EE44) begin n_fail++; $display("FAIL abandoned_store_mem got %h want 1122ee44", mem[1]); end
   endtask

   initial begin
      test_reset();
      test_loads();
      test_lat3_back_to_back();
      test_subword_store();
      test_boundary();
      test_misalign();
      test_reset_mid_write();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
